// File: rtl/nv_nvdla_cdma_wt_rd_req_gen_if.sv
// Handshake bundle between the weight read-request generator and its environment:
// command intake, request output toward the pipe stage, and response credit return.
interface nv_nvdla_cdma_wt_rd_req_gen_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [19:0] cmd_atoms;
  logic        dma_rd_req_vld;
  logic        dma_rd_req_rdy;
  logic [78:0] dma_rd_req_pd;
  logic        rsp_atom_done;

  // Environment side: issues commands, accepts requests, returns credits
  modport master (
    output cmd_valid, cmd_addr, cmd_atoms, dma_rd_req_rdy, rsp_atom_done,
    input  cmd_ready, dma_rd_req_vld, dma_rd_req_pd
  );

  // Generator side
  modport slave (
    input  cmd_valid, cmd_addr, cmd_atoms, dma_rd_req_rdy, rsp_atom_done,
    output cmd_ready, dma_rd_req_vld, dma_rd_req_pd
  );
endinterface

// File: rtl/nv_nvdla_cdma_wt_rd_req_gen.sv
// Weight-fetch read-request generator: splits one weight-load command into
// atom requests that never cross 4 KB and are gated by response-buffer credit.
module nv_nvdla_cdma_wt_rd_req_gen #(
  parameter int unsigned MAX_REQ_ATOMS = 8,
  parameter int unsigned BUF_ATOMS     = 256
) (
  input  logic                                nvdla_core_clk,
  input  logic                                nvdla_core_rst,
  nv_nvdla_cdma_wt_rd_req_gen_if.slave        rd_if,
  output logic                                busy,
  output logic                                cmd_done,
  output logic                                credit_err
);

  localparam int unsigned AW = 64;
  localparam int unsigned RW = 20;
  localparam int unsigned SW = 15;
  localparam int unsigned PW = AW + SW;
  localparam int unsigned OW = $clog2(BUF_ATOMS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [RW-1:0] remaining;
  logic [OW-1:0] outstanding;

  logic          cmd_hs_c;
  logic          req_hs_c;
  logic          rsp_dec_c;
  logic          err_c;
  logic          credit_ok_c;
  logic [RW-1:0] cur_chunk_c;
  logic [RW-1:0] base_rem_c;
  logic [RW-1:0] bnd_c;
  logic [RW-1:0] chunk_c;
  logic [AW-1:0] base_addr_c;
  logic [OW-1:0] out_nxt_c;
  logic          unused_addr_lsb_c;

  // Next request candidate: derived from the command in IDLE, else from the post-handshake position
  always_comb begin
    cmd_hs_c    = rd_if.cmd_valid & rd_if.cmd_ready;
    req_hs_c    = rd_if.dma_rd_req_vld & rd_if.dma_rd_req_rdy;
    cur_chunk_c = RW'(rd_if.dma_rd_req_pd[PW-1:AW]) + RW'(1);
    base_addr_c = addr;
    base_rem_c  = remaining;
    if (state == ST_IDLE) begin
      base_addr_c = {rd_if.cmd_addr[AW-1:5], 5'b0};
      base_rem_c  = rd_if.cmd_atoms;
    end else if (req_hs_c) begin
      base_addr_c = addr + (AW'(cur_chunk_c) << 5);
      base_rem_c  = remaining - cur_chunk_c;
    end

    // Atoms left in the current 4 KB page is always 1..128
    bnd_c   = RW'(8'd128 - {1'b0, base_addr_c[11:5]});
    chunk_c = base_rem_c;
    if (chunk_c > RW'(MAX_REQ_ATOMS)) chunk_c = RW'(MAX_REQ_ATOMS);
    if (chunk_c > bnd_c)              chunk_c = bnd_c;

    // Handshake and response in the same cycle are both applied
    rsp_dec_c   = rd_if.rsp_atom_done & (outstanding != '0);
    err_c       = rd_if.rsp_atom_done & (outstanding == '0);
    out_nxt_c   = outstanding + (req_hs_c ? OW'(cur_chunk_c) : OW'(0)) - OW'(rsp_dec_c);
    credit_ok_c = (32'(BUF_ATOMS) - 32'(out_nxt_c)) >= 32'(chunk_c);
  end

  assign unused_addr_lsb_c = ^rd_if.cmd_addr[4:0];

  // Control FSM with registered outputs; a held request is never re-evaluated
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state                <= ST_IDLE;
      addr                 <= '0;
      remaining            <= '0;
      outstanding          <= '0;
      rd_if.cmd_ready      <= 1'b1;
      rd_if.dma_rd_req_vld <= 1'b0;
      rd_if.dma_rd_req_pd  <= '0;
      busy                 <= 1'b0;
      cmd_done             <= 1'b0;
      credit_err           <= 1'b0;
    end else begin
      outstanding <= out_nxt_c;
      cmd_done    <= 1'b0;
      if (err_c) credit_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_hs_c) begin
            if (rd_if.cmd_atoms == '0) begin
              cmd_done <= 1'b1;
            end else begin
              state                <= ST_REQ;
              rd_if.cmd_ready      <= 1'b0;
              busy                 <= 1'b1;
              addr                 <= base_addr_c;
              remaining            <= base_rem_c;
              rd_if.dma_rd_req_vld <= credit_ok_c;
              rd_if.dma_rd_req_pd  <= {SW'(chunk_c - RW'(1)), base_addr_c};
            end
          end
        end

        ST_REQ: begin
          if (!rd_if.dma_rd_req_vld || rd_if.dma_rd_req_rdy) begin
            addr      <= base_addr_c;
            remaining <= base_rem_c;
            if (base_rem_c == '0) begin
              state                <= ST_WAIT;
              rd_if.dma_rd_req_vld <= 1'b0;
            end else begin
              rd_if.dma_rd_req_vld <= credit_ok_c;
              if (credit_ok_c) rd_if.dma_rd_req_pd <= {SW'(chunk_c - RW'(1)), base_addr_c};
            end
          end
        end

        ST_WAIT: begin
          if (outstanding == '0) begin
            state           <= ST_IDLE;
            rd_if.cmd_ready <= 1'b1;
            busy            <= 1'b0;
            cmd_done        <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
